// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS core support blocks.
package mips_pkg;

   // Default machine word width for the cores and their memories
   localparam int WORD_W = 32;

   // Boot sequencer states; the encoding is visible to the host on state_out
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      RUN  = 3'd2,
      DUMP = 3'd3,
      DONE = 3'd4,
      ERR  = 3'd5
   } boot_state_t;

endpackage

// File: rtl/mips_boot_ctrl.sv
// mips_boot_ctrl: boot/run/dump sequencer for the MIPS cores.
// Streams a host program into instruction memory while the core is held in
// reset, releases the core until the done word in data memory goes nonzero
// (or a cycle timeout expires), then streams a window of data memory back.
// Optional feature macro: BOOT_CTRL_CHECKSUM_EN adds a wrapping-sum check of
// the loaded program against a host-supplied expected sum.
module mips_boot_ctrl
   import mips_pkg::*;
#(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = WORD_W,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int DONE_ADDR      = 255,
   parameter int DUMP_BASE      = 0,
   parameter int DUMP_WORDS     = 16
) (
   input  logic                  clock_in,
   input  logic                  reset_in,
   input  logic                  start_in,
   input  logic [ADDR_WIDTH:0]   load_count_in,
   input  logic                  host_valid_in,
   input  logic [DATA_WIDTH-1:0] host_data_in,
   output logic                  host_ready_out,
   output logic                  core_reset_out,
   output logic                  instrWrite_out,
   output logic [ADDR_WIDTH-1:0] instr_address_out,
   output logic [DATA_WIDTH-1:0] instr_out,
   output logic [ADDR_WIDTH-1:0] read_data_address_out,
   input  logic [DATA_WIDTH-1:0] read_data_in,
   output logic                  dump_valid_out,
   output logic [DATA_WIDTH-1:0] dump_data_out,
   input  logic                  dump_ready_in,
`ifdef BOOT_CTRL_CHECKSUM_EN
   input  logic [DATA_WIDTH-1:0] expected_sum_in,
   output logic [DATA_WIDTH-1:0] checksum_out,
`endif
   output logic [2:0]            state_out,
   output logic [31:0]           cycles_out
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0]         MAX_WORDS   = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [CW-1:0]         DUMP_LAST   = CW'(DUMP_WORDS - 1);
   localparam logic [ADDR_WIDTH-1:0] DONE_ADDR_C = ADDR_WIDTH'(DONE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] DUMP_BASE_C = ADDR_WIDTH'(DUMP_BASE);
   localparam logic [31:0]           TIMEOUT_C   = 32'(TIMEOUT_CYCLES);

   boot_state_t   state_q, state_d;
   logic [CW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] idx_q, idx_d;
   logic [31:0]   cycles_q, cycles_d;
   logic [31:0]   runCount;
`ifdef BOOT_CTRL_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] sum_q, sum_d;
   logic [DATA_WIDTH-1:0] expect_q, expect_d;
`endif

   // Next-state logic: start acceptance, load pointer, run timer and dump index
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      count_d  = count_q;
      idx_d    = idx_q;
      cycles_d = cycles_q;
`ifdef BOOT_CTRL_CHECKSUM_EN
      sum_d    = sum_q;
      expect_d = expect_q;
`endif
      runCount = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
      case (state_q)
         IDLE, DONE, ERR: begin
            if (start_in) begin
               ptr_d    = '0;
               idx_d    = '0;
               cycles_d = '0;
               count_d  = (load_count_in > MAX_WORDS) ? MAX_WORDS : load_count_in;
`ifdef BOOT_CTRL_CHECKSUM_EN
               sum_d    = '0;
               expect_d = expected_sum_in;
`endif
               state_d  = (load_count_in == '0) ? RUN : LOAD;
            end
         end
         LOAD: begin
            if (host_valid_in) begin
               ptr_d = ptr_q + 1'b1;
`ifdef BOOT_CTRL_CHECKSUM_EN
               sum_d = sum_q + host_data_in;
`endif
               if (ptr_q == count_q - 1'b1) begin
`ifdef BOOT_CTRL_CHECKSUM_EN
                  state_d = (sum_d == expect_q) ? RUN : ERR;
`else
                  state_d = RUN;
`endif
               end
            end
         end
         RUN: begin
            cycles_d = runCount;
            if (read_data_in != '0) begin
               state_d = DUMP;
            end else if (runCount >= TIMEOUT_C) begin
               state_d = ERR;
            end
         end
         DUMP: begin
            if (dump_ready_in) begin
               idx_d = idx_q + 1'b1;
               if (idx_q == DUMP_LAST) begin
                  state_d = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and counter registers with synchronous active-low reset
   always_ff @(posedge clock_in) begin
      if (!reset_in) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         count_q  <= '0;
         idx_q    <= '0;
         cycles_q <= '0;
`ifdef BOOT_CTRL_CHECKSUM_EN
         sum_q    <= '0;
         expect_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         count_q  <= count_d;
         idx_q    <= idx_d;
         cycles_q <= cycles_d;
`ifdef BOOT_CTRL_CHECKSUM_EN
         sum_q    <= sum_d;
         expect_q <= expect_d;
`endif
      end
   end

   // Output decode from the registered state; write and dump data pass straight through
   assign host_ready_out        = (state_q == LOAD);
   assign core_reset_out        = (state_q == RUN);
   assign instrWrite_out        = (state_q == LOAD) && host_valid_in;
   assign instr_address_out     = (state_q == LOAD) ? ptr_q[ADDR_WIDTH-1:0] : '0;
   assign instr_out             = instrWrite_out ? host_data_in : '0;
   assign read_data_address_out = (state_q == RUN)  ? DONE_ADDR_C :
                                  (state_q == DUMP) ? DUMP_BASE_C + idx_q[ADDR_WIDTH-1:0] : '0;
   assign dump_valid_out        = (state_q == DUMP);
   assign dump_data_out         = (state_q == DUMP) ? read_data_in : '0;
   assign state_out             = state_q;
   assign cycles_out            = cycles_q;
`ifdef BOOT_CTRL_CHECKSUM_EN
   assign checksum_out          = sum_q;
`endif

endmodule

// File: tb/tb_mips_boot_ctrl.sv
// tb_mips_boot_ctrl: randomized self-checking bench for mips_boot_ctrl.
// A small core model raises the done word after a chosen number of RUN
// cycles; expected writes, run length and dump contents come from a
// reference model built from the program and data-memory image.
// Build with BOOT_CTRL_CHECKSUM_EN defined to also exercise the checksum.
module tb_mips_boot_ctrl;

   localparam int AW     = 8;
   localparam int DW     = 32;
   localparam int TMO    = 16;
   localparam int DONEA  = 255;
   localparam int DBASE  = 248;
   localparam int DWORDS = 16;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_RUN  = 3'd2;
   localparam logic [2:0] ST_DUMP = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;
   localparam logic [2:0] ST_ERR  = 3'd5;
   localparam logic [31:0] DONE_VAL = 32'hC0DE_0001;

   logic          clock = 1'b0;
   logic          resetIn, startIn, hostValid, dumpReady;
   logic [AW:0]   loadCount;
   logic [DW-1:0] hostData;
   logic          hostReady, coreReset, instrWrite, dumpValid;
   logic [AW-1:0] instrAddr, readAddr;
   logic [DW-1:0] instrData, readData, dumpData;
   logic [2:0]    stateOut;
   logic [31:0]   cyclesOut;
`ifdef BOOT_CTRL_CHECKSUM_EN
   logic [DW-1:0] expectedSum, checksumOut;
`endif

   logic [DW-1:0] dmem [256];
   int            doneAt = 1000;
   int            runCyc = 0;
   bit            doneFlag = 1'b0;
   logic [AW-1:0] wrAddrQ [$];
   logic [DW-1:0] wrDataQ [$];
   logic [DW-1:0] dumpQ [$];
   logic [AW-1:0] dumpAddrQ [$];
   int            holdViol = 0;
   bit            holdPrev = 1'b0;
   logic [DW-1:0] holdData = '0;
   int            testCount = 0;
   int            failCount = 0;

   mips_boot_ctrl #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO),
      .DONE_ADDR(DONEA), .DUMP_BASE(DBASE), .DUMP_WORDS(DWORDS)
   ) dut (
      .clock_in(clock),
      .reset_in(resetIn),
      .start_in(startIn),
      .load_count_in(loadCount),
      .host_valid_in(hostValid),
      .host_data_in(hostData),
      .host_ready_out(hostReady),
      .core_reset_out(coreReset),
      .instrWrite_out(instrWrite),
      .instr_address_out(instrAddr),
      .instr_out(instrData),
      .read_data_address_out(readAddr),
      .read_data_in(readData),
      .dump_valid_out(dumpValid),
      .dump_data_out(dumpData),
      .dump_ready_in(dumpReady),
`ifdef BOOT_CTRL_CHECKSUM_EN
      .expected_sum_in(expectedSum),
      .checksum_out(checksumOut),
`endif
      .state_out(stateOut),
      .cycles_out(cyclesOut)
   );

   always #5 clock = ~clock;

   // Data memory read port; the done word reads back once the core model has written it
   assign readData = (readAddr == AW'(DONEA) && doneFlag) ? DONE_VAL : dmem[readAddr];

   // Core model: counts released cycles and writes the done word at cycle doneAt
   always @(negedge clock) begin
      if (coreReset) begin
         runCyc = runCyc + 1;
         if (runCyc == doneAt) doneFlag = 1'b1;
      end else begin
         runCyc = 0;
         if (stateOut != ST_DUMP) doneFlag = 1'b0;
      end
   end

   // Monitor: records instruction writes and accepted dump words, tracks dump stability
   always @(negedge clock) begin
      if (instrWrite) begin
         wrAddrQ.push_back(instrAddr);
         wrDataQ.push_back(instrData);
      end
      if (dumpValid && dumpReady) begin
         dumpQ.push_back(dumpData);
         dumpAddrQ.push_back(readAddr);
      end
      if (holdPrev && dumpValid && dumpData !== holdData) holdViol = holdViol + 1;
      holdPrev = dumpValid && !dumpReady;
      holdData = dumpData;
   end

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One full boot: optional load, run until done or timeout, dump, then compare with the model
   task automatic applyStimulus(input int n, input int dAt, input int gapMax, input bit pokeStart, input bit toggleReady);
      int            nEff, wrBase, dmBase, holdBase, budget, cyc, a;
      bit            ready, finished, expErr, loadOk;
      logic [DW-1:0] prog [$];
      logic [DW-1:0] expWord;
      logic [2:0]    st;
`ifdef BOOT_CTRL_CHECKSUM_EN
      logic [DW-1:0] sum;
`endif
      nEff   = (n > 256) ? 256 : n;
      expErr = (dAt > TMO);
      for (int i = 0; i < 256; i++) dmem[i] = $urandom;
      dmem[DONEA] = '0;
      for (int i = 0; i < nEff; i++) prog.push_back($urandom);
`ifdef BOOT_CTRL_CHECKSUM_EN
      sum = '0;
      for (int i = 0; i < nEff; i++) sum = sum + prog[i];
      expectedSum = sum;
`endif
      doneAt   = dAt;
      wrBase   = wrAddrQ.size();
      dmBase   = dumpQ.size();
      holdBase = holdViol;

      @(posedge clock); #1;
      startIn   = 1'b1;
      loadCount = (AW+1)'(n);
      @(posedge clock); #1;
      startIn   = 1'b0;

      loadOk = 1'b1;
      for (int i = 0; i < nEff && loadOk; i++) begin
         repeat ($urandom_range(0, gapMax)) begin
            @(posedge clock); #1;
         end
         hostValid = 1'b1;
         hostData  = prog[i];
         budget    = 0;
         do begin
            @(negedge clock);
            ready = hostReady;
            @(posedge clock); #1;
            budget++;
         end while (!ready && budget < 50);
         hostValid = 1'b0;
         if (!ready) begin
            checkOutput("load handshake timeout", 32'd0, 32'd1);
            loadOk = 1'b0;
         end
      end

      finished = 1'b0;
      cyc      = 0;
      while (!finished && cyc < 3000) begin
         @(negedge clock);
         st = stateOut;
         if (st == ST_DONE || st == ST_ERR) begin
            finished = 1'b1;
         end else begin
            @(posedge clock); #1;
            dumpReady = toggleReady ? ~dumpReady : 1'($urandom_range(0, 1));
            startIn   = pokeStart && !expErr && (st == ST_RUN) && ($urandom_range(0, 2) == 0);
            loadCount = (AW+1)'(5);
            cyc++;
         end
      end
      startIn   = 1'b0;
      dumpReady = 1'b0;

      checkOutput("run completion", 32'(finished), 32'd1);
      checkOutput("final state", 32'(stateOut), expErr ? 32'(ST_ERR) : 32'(ST_DONE));
      checkOutput("cycles_out", cyclesOut, expErr ? 32'(TMO) : 32'(dAt));
      checkOutput("core_reset_out held", 32'(coreReset), 32'd0);
      checkOutput("host_ready_out idle", 32'(hostReady), 32'd0);
      checkOutput("write count", 32'(wrAddrQ.size() - wrBase), 32'(nEff));
      for (int i = 0; i < nEff && wrBase + i < wrAddrQ.size(); i++) begin
         checkOutput("write address", 32'(wrAddrQ[wrBase+i]), 32'(i));
         checkOutput("write data", wrDataQ[wrBase+i], prog[i]);
      end
      checkOutput("dump count", 32'(dumpQ.size() - dmBase), expErr ? 32'd0 : 32'(DWORDS));
      for (int i = 0; i < DWORDS && !expErr && dmBase + i < dumpQ.size(); i++) begin
         a       = (DBASE + i) % 256;
         expWord = (a == DONEA) ? DONE_VAL : dmem[a];
         checkOutput("dump address", 32'(dumpAddrQ[dmBase+i]), 32'(a));
         checkOutput("dump data", dumpQ[dmBase+i], expWord);
      end
      checkOutput("dump data held while stalled", 32'(holdViol - holdBase), 32'd0);
   endtask

   // Abort a load half way through with reset and confirm everything returns to idle
   task automatic resetMidLoad();
      @(posedge clock); #1;
      startIn   = 1'b1;
      loadCount = (AW+1)'(4);
      @(posedge clock); #1;
      startIn   = 1'b0;
      for (int i = 0; i < 2; i++) begin
         hostValid = 1'b1;
         hostData  = $urandom;
         @(posedge clock); #1;
      end
      hostData = $urandom;
      resetIn  = 1'b0;
      @(posedge clock); #1;
      resetIn  = 1'b1;
      @(negedge clock);
      checkOutput("mid-load reset state", 32'(stateOut), 32'(ST_IDLE));
      checkOutput("mid-load reset host_ready", 32'(hostReady), 32'd0);
      checkOutput("mid-load reset no write", 32'(instrWrite), 32'd0);
      checkOutput("mid-load reset core held", 32'(coreReset), 32'd0);
      hostValid = 1'b0;
   endtask

`ifdef BOOT_CTRL_CHECKSUM_EN
   // Load {1,2,3} against a given expected sum and check where the load ends up
   task automatic checksumRun(input logic [DW-1:0] expSum, input logic [2:0] expState);
      doneAt = 1000;
      @(posedge clock); #1;
      startIn     = 1'b1;
      loadCount   = (AW+1)'(3);
      expectedSum = expSum;
      @(posedge clock); #1;
      startIn = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         hostValid = 1'b1;
         hostData  = DW'(i);
         @(posedge clock); #1;
      end
      hostValid = 1'b0;
      @(negedge clock);
      checkOutput("checksum end state", 32'(stateOut), 32'(expState));
      checkOutput("checksum_out", checksumOut, 32'd6);
      @(posedge clock); #1;
      resetIn = 1'b0;
      @(posedge clock); #1;
      resetIn = 1'b1;
   endtask
`endif

   // Overall timeout so the bench always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence
   initial begin
      resetIn   = 1'b0;
      startIn   = 1'b0;
      hostValid = 1'b0;
      hostData  = '0;
      dumpReady = 1'b0;
      loadCount = '0;
`ifdef BOOT_CTRL_CHECKSUM_EN
      expectedSum = '0;
`endif
      for (int i = 0; i < 256; i++) dmem[i] = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("reset state", 32'(stateOut), 32'(ST_IDLE));
      checkOutput("reset host_ready", 32'(hostReady), 32'd0);
      checkOutput("reset core_reset", 32'(coreReset), 32'd0);
      checkOutput("reset cycles_out", cyclesOut, 32'd0);
      checkOutput("reset dump_valid", 32'(dumpValid), 32'd0);
      checkOutput("reset read address", 32'(readAddr), 32'd0);
      @(posedge clock); #1;
      resetIn = 1'b1;

      $display("[TB] load 4, done at cycle 9, toggling dump ready");
      applyStimulus(4, 9, 0, 1'b0, 1'b1);
      $display("[TB] timeout run");
      applyStimulus(3, 100, 0, 1'b0, 1'b0);
      $display("[TB] reset during load, then start pokes during run");
      resetMidLoad();
      applyStimulus(4, 6, 0, 1'b1, 1'b0);
      $display("[TB] host gaps of up to 3 cycles");
      applyStimulus(6, 12, 3, 1'b0, 1'b0);
      $display("[TB] zero-length load reuses program");
      applyStimulus(0, 4, 0, 1'b0, 1'b1);
      $display("[TB] done on the timeout cycle, then one past it");
      applyStimulus(2, TMO, 0, 1'b0, 1'b0);
      applyStimulus(2, TMO + 1, 0, 1'b0, 1'b0);
      $display("[TB] done on the first run cycle");
      applyStimulus(1, 1, 1, 1'b0, 1'b0);
      $display("[TB] oversized load count clamps to memory depth");
      applyStimulus(300, 3, 0, 1'b0, 1'b1);
      $display("[TB] random runs");
      for (int r = 0; r < 8; r++) begin
         applyStimulus($urandom_range(0, 20), $urandom_range(1, 20), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
`ifdef BOOT_CTRL_CHECKSUM_EN
      $display("[TB] checksum mismatch and match");
      checksumRun(32'd7, ST_ERR);
      checksumRun(32'd6, ST_RUN);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", testCount, failCount);
      $finish;
   end

endmodule
